// File: rtl/afifo_pkg.sv
// afifo_pkg: definitions shared between the afifo asynchronous FIFO and its
// read-side drain controller.
//   - default data width / prefetch depth / read latency constants
//   - drain FSM state encoding
package afifo_pkg;

    localparam int F_WIDTH_DEF   = 8;
    localparam int BUF_DEPTH_DEF = 4;
    localparam int RD_LAT_DEF    = 1;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        BURST  = 2'b01,
        SINGLE = 2'b10
    } drain_state_t;

endpackage

// File: rtl/drain_buf.sv
// drain_buf: circular prefetch buffer for the FIFO drain controller.
// Ports:
//   i_clk, i_rst_n  clock, asynchronous active-low reset
//   i_push, i_data  write one word at the tail
//   i_pop           drop the head word (caller only pops when o_count != 0)
//   o_data          head word, 0 while the buffer is empty
//   o_count         occupancy, 0..BUF_DEPTH
module drain_buf
    import afifo_pkg::*;
#(
    parameter  int F_WIDTH   = F_WIDTH_DEF,
    parameter  int BUF_DEPTH = BUF_DEPTH_DEF,
    localparam int PTR_W     = $clog2(BUF_DEPTH),
    localparam int CNT_W     = PTR_W + 1
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_push,
    input  logic [F_WIDTH-1:0] i_data,
    input  logic               i_pop,
    output logic [F_WIDTH-1:0] o_data,
    output logic [CNT_W-1:0]   o_count
);

    logic [F_WIDTH-1:0] r_mem [BUF_DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_count;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            // Pointers are exactly log2(BUF_DEPTH) wide, so they wrap for free.
            if (i_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (i_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // NOTE: the storage array has no reset; validity comes from r_count, so
    // clearing it would only cost reset fan-out.
    always_ff @(posedge i_clk) begin
        if (i_push) r_mem[r_wr_ptr] <= i_data;
    end

    // Gate the head so stale or never-written entries never show downstream.
    assign o_data  = (r_count != '0) ? r_mem[r_rd_ptr] : '0;
    assign o_count = r_count;

endmodule

// File: rtl/fifo_drain_ctrl.sv
// fifo_drain_ctrl: read-clock-domain drain controller for afifo.
// Pops the FIFO with a registered r_en, tracks returning data through an
// RD_LAT-deep valid pipe, stores it in a prefetch buffer and presents the
// buffer head as a valid/ready stream.
// Ports:
//   r_clk, reset             clock, asynchronous active-low reset
//   f_empty_flag             FIFO empty (synchronized, may lag)
//   f_almost_empty_flag      FIFO almost empty (synchronized, may lag)
//   d_out                    FIFO read data, valid RD_LAT cycles after r_en
//   r_en                     registered FIFO pop request
//   m_data, m_valid, m_ready downstream stream
//   rd_count                 total pops, 16-bit wrapping
//   busy                     FSM active, pops in flight or buffer occupied
// RD_LAT must be 1 or 2; BUF_DEPTH a power of two >= 2.
module fifo_drain_ctrl
    import afifo_pkg::*;
#(
    parameter int F_WIDTH   = F_WIDTH_DEF,
    parameter int BUF_DEPTH = BUF_DEPTH_DEF,
    parameter int RD_LAT    = RD_LAT_DEF
) (
    input  logic               r_clk,
    input  logic               reset,
    input  logic               f_empty_flag,
    input  logic               f_almost_empty_flag,
    input  logic [F_WIDTH-1:0] d_out,
    output logic               r_en,
    output logic [F_WIDTH-1:0] m_data,
    output logic               m_valid,
    input  logic               m_ready,
    output logic [15:0]        rd_count,
    output logic               busy
);

    localparam int CNT_W = $clog2(BUF_DEPTH) + 1;

    drain_state_t       r_state;
    drain_state_t       w_state_next;
    logic [RD_LAT-1:0]  r_vpipe;
    logic [CNT_W-1:0]   r_inflight;
    logic [CNT_W-1:0]   w_occ;
    logic [CNT_W:0]     w_credit_sum;
    logic               w_capture;
    logic               w_accept;
    logic               w_credit_ok;
    logic               w_single_ok;
    logic               w_issue;

    assign w_capture = r_vpipe[RD_LAT-1];
    assign w_accept  = m_valid & m_ready;

    // Words that will be resident once this edge settles. r_inflight already
    // counts the r_en currently on the wire; a capture only moves a word from
    // the pipe into the buffer, so it does not change the total.
    assign w_credit_sum = {1'b0, w_occ} + {1'b0, r_inflight}
                        - {{CNT_W{1'b0}}, w_accept};
    assign w_credit_ok  = (w_credit_sum < (CNT_W + 1)'(BUF_DEPTH));

    // SINGLE may re-issue in the cycle its previous word lands, giving one
    // pop per RD_LAT+1 cycles with never more than one outstanding.
    assign w_single_ok = (r_inflight == {{(CNT_W - 1){1'b0}}, w_capture});

    // NOTE: every signal written here gets a default first, so no path
    // through the block can leave it unassigned and infer a latch.
    always_comb begin
        w_state_next = r_state;
        w_issue      = 1'b0;

        // Empty wins over almost-empty from every state.
        unique case (r_state)
            IDLE: begin
                if (!f_empty_flag)
                    w_state_next = f_almost_empty_flag ? SINGLE : BURST;
            end
            BURST: begin
                if (f_empty_flag)             w_state_next = IDLE;
                else if (f_almost_empty_flag) w_state_next = SINGLE;
            end
            SINGLE: begin
                if (f_empty_flag)              w_state_next = IDLE;
                else if (!f_almost_empty_flag) w_state_next = BURST;
            end
            default: w_state_next = IDLE;
        endcase

        // Pop policy follows the state chosen from this cycle's flags, so a
        // freshly sampled empty or almost-empty takes effect on the very next
        // r_en rather than one cycle late.
        unique case (w_state_next)
            BURST:   w_issue = w_credit_ok;
            SINGLE:  w_issue = w_credit_ok & w_single_ok;
            default: w_issue = 1'b0;
        endcase
    end

    always_ff @(posedge r_clk or negedge reset) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_en       <= 1'b0;
            r_vpipe    <= '0;
            r_inflight <= '0;
            rd_count   <= '0;
        end else begin
            r_state    <= w_state_next;
            r_en       <= w_issue;
            // Bit 0 is the pop the FIFO just sampled; the top bit marks the
            // cycle its data sits on d_out.
            r_vpipe    <= (r_vpipe << 1) | RD_LAT'(r_en);
            r_inflight <= r_inflight + CNT_W'(w_issue) - CNT_W'(w_capture);
            if (r_en) rd_count <= rd_count + 16'd1;
        end
    end

    drain_buf #(
        .F_WIDTH   (F_WIDTH),
        .BUF_DEPTH (BUF_DEPTH)
    ) u_buf (
        .i_clk   (r_clk),
        .i_rst_n (reset),
        .i_push  (w_capture),
        .i_data  (d_out),
        .i_pop   (w_accept),
        .o_data  (m_data),
        .o_count (w_occ)
    );

    assign m_valid = (w_occ != '0);
    assign busy    = (r_state != IDLE) | (r_inflight != '0) | (w_occ != '0);

endmodule

// File: tb/tb_fifo_drain_ctrl.sv
// Testbench for fifo_drain_ctrl. A queue-based FIFO model supplies data with
// RD_LAT latency and flags derived from its fill level; a scoreboard checks
// that downstream words appear in exactly the order they were popped.
module tb_fifo_drain_ctrl;

    localparam int F_WIDTH   = 8;
    localparam int BUF_DEPTH = 4;
    localparam int RD_LAT    = 1;

    logic               r_clk = 1'b0;
    logic               reset = 1'b0;
    logic               f_empty_flag = 1'b1;
    logic               f_almost_empty_flag = 1'b1;
    logic [F_WIDTH-1:0] d_out;
    logic               r_en;
    logic [F_WIDTH-1:0] m_data;
    logic               m_valid;
    logic               m_ready = 1'b0;
    logic [15:0]        rd_count;
    logic               busy;

    int errors = 0;
    int checks = 0;

    fifo_drain_ctrl #(
        .F_WIDTH   (F_WIDTH),
        .BUF_DEPTH (BUF_DEPTH),
        .RD_LAT    (RD_LAT)
    ) dut (
        .r_clk               (r_clk),
        .reset               (reset),
        .f_empty_flag        (f_empty_flag),
        .f_almost_empty_flag (f_almost_empty_flag),
        .d_out               (d_out),
        .r_en                (r_en),
        .m_data              (m_data),
        .m_valid             (m_valid),
        .m_ready             (m_ready),
        .rd_count            (rd_count),
        .busy                (busy)
    );

    always #5 r_clk = ~r_clk;

    // ---------------- FIFO model and scoreboard ----------------
    logic [F_WIDTH-1:0] fifo_q [$];   // words still in the FIFO
    logic [F_WIDTH-1:0] exp_q  [$];   // popped, not yet accepted downstream
    logic [F_WIDTH-1:0] acc_q  [$];   // accepted downstream
    logic [F_WIDTH-1:0] dpipe [RD_LAT] = '{default: '0};
    logic [F_WIDTH-1:0] mdl_word;
    logic [F_WIDTH-1:0] mdl_head;
    int                 pop_cycles [$];
    int                 cyc = 0;
    int                 ae_thr = 1;
    bit                 flags_random = 1'b0;
    int                 underflows = 0;
    int                 max_out = 0;
    int                 empty_viol = 0;
    bit                 empty_at_edge = 1'b0;

    assign d_out = dpipe[RD_LAT-1];

    always @(posedge r_clk) begin
        cyc++;
        empty_at_edge = f_empty_flag;
        if (!reset) begin
            exp_q.delete();
        end else if (m_valid && m_ready) begin
            acc_q.push_back(m_data);
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL accept_order: got %0h, expected no pending word", m_data);
            end else begin
                mdl_head = exp_q.pop_front();
                if (m_data !== mdl_head) begin
                    errors++;
                    $display("FAIL accept_order: got %0h, expected %0h", m_data, mdl_head);
                end
            end
        end
        mdl_word = dpipe[0];
        if (r_en) begin
            pop_cycles.push_back(cyc);
            if (fifo_q.size() == 0) underflows++;
            else begin
                mdl_word = fifo_q.pop_front();
                exp_q.push_back(mdl_word);
            end
        end
        if (exp_q.size() > max_out) max_out = exp_q.size();
        for (int i = RD_LAT - 1; i > 0; i--) dpipe[i] <= dpipe[i-1];
        dpipe[0] <= mdl_word;
    end

    // Flags follow the model's fill level, updated away from the sampling edge.
    always @(negedge r_clk) begin
        if (flags_random) begin
            f_empty_flag        = 1'($urandom_range(0, 1));
            f_almost_empty_flag = 1'($urandom_range(0, 1));
        end else begin
            f_empty_flag        = (fifo_q.size() == 0);
            f_almost_empty_flag = (fifo_q.size() <= ae_thr);
        end
        if (empty_at_edge && r_en) empty_viol++;
    end

    task automatic wait_drained(input int budget, input bit rand_ready, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge r_clk);
            if (rand_ready) m_ready = ($urandom_range(0, 3) != 0);
            if (fifo_q.size() == 0 && exp_q.size() == 0 && !busy) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b0;
        flags_random = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge r_clk);
            m_ready = 1'($urandom_range(0, 1));
            checks++;
            if ({r_en, m_valid, busy, rd_count, m_data} !== '0) begin
                errors++;
                $display("FAIL reset_outputs: r_en=%b m_valid=%b busy=%b rd_count=%0h m_data=%0h, expected all 0",
                         r_en, m_valid, busy, rd_count, m_data);
            end
        end
        flags_random = 1'b0;
        m_ready = 1'b0;
        repeat (2) @(negedge r_clk);
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge r_clk);
            checks++;
            if (r_en !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL reset_release_idle: r_en=%b busy=%b, expected 0 0", r_en, busy);
            end
        end
    endtask

    task automatic test_burst_stall();
        bit ok;
        acc_q.delete();
        max_out = 0;
        ae_thr = 1;
        m_ready = 1'b0;
        for (int i = 0; i < 10; i++) fifo_q.push_back(F_WIDTH'(2 * i + 1));
        repeat (20) @(negedge r_clk);
        checks++;
        if (rd_count !== 16'd4) begin
            errors++;
            $display("FAIL stall_pops: rd_count=%0d, expected %0d", rd_count, BUF_DEPTH);
        end
        checks++;
        if (fifo_q.size() != 6) begin
            errors++;
            $display("FAIL stall_fifo_left: %0d words, expected 6", fifo_q.size());
        end
        checks++;
        if (m_valid !== 1'b1 || m_data !== F_WIDTH'(1)) begin
            errors++;
            $display("FAIL stall_head: m_valid=%b m_data=%0h, expected 1 1", m_valid, m_data);
        end
        m_ready = 1'b1;
        wait_drained(100, 1'b0, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL stall_drain_timeout: busy=%b fifo=%0d, expected drained", busy, fifo_q.size());
        end
        checks++;
        if (acc_q.size() != 10) begin
            errors++;
            $display("FAIL stall_count: %0d words accepted, expected 10", acc_q.size());
        end
        for (int i = 0; i < 10 && i < acc_q.size(); i++) begin
            checks++;
            if (acc_q[i] !== F_WIDTH'(2 * i + 1)) begin
                errors++;
                $display("FAIL stall_seq[%0d]: got %0d, expected %0d", i, acc_q[i], 2 * i + 1);
            end
        end
        checks++;
        if (rd_count !== 16'd10 || max_out > BUF_DEPTH) begin
            errors++;
            $display("FAIL stall_totals: rd_count=%0d max_out=%0d, expected 10 and <=%0d",
                     rd_count, max_out, BUF_DEPTH);
        end
    endtask

    task automatic test_throttle();
        bit ok;
        int base;
        base = int'(rd_count);
        ae_thr = 100;
        m_ready = 1'b1;
        pop_cycles.delete();
        for (int i = 0; i < 3; i++) fifo_q.push_back(F_WIDTH'($urandom));
        wait_drained(60, 1'b0, ok);
        repeat (10) @(negedge r_clk);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL throttle_drain_timeout: fifo=%0d, expected drained", fifo_q.size());
        end
        checks++;
        if (pop_cycles.size() != 3) begin
            errors++;
            $display("FAIL throttle_pops: %0d pops, expected 3", pop_cycles.size());
        end
        for (int i = 1; i < pop_cycles.size(); i++) begin
            checks++;
            if (pop_cycles[i] - pop_cycles[i-1] != RD_LAT + 1) begin
                errors++;
                $display("FAIL throttle_spacing[%0d]: %0d cycles, expected %0d",
                         i, pop_cycles[i] - pop_cycles[i-1], RD_LAT + 1);
            end
        end
        checks++;
        if (rd_count !== 16'(base + 3) || underflows != 0 || empty_viol != 0) begin
            errors++;
            $display("FAIL throttle_totals: rd_count=%0d underflows=%0d empty_viol=%0d, expected %0d 0 0",
                     rd_count, underflows, empty_viol, base + 3);
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        int base;
        base = int'(rd_count);
        max_out = 0;
        ae_thr = 1;
        m_ready = 1'b0;
        for (int i = 0; i < 24; i++) fifo_q.push_back(F_WIDTH'($urandom));
        repeat (12) @(negedge r_clk);
        checks++;
        if (rd_count !== 16'(base + BUF_DEPTH) || m_valid !== 1'b1) begin
            errors++;
            $display("FAIL b2b_fill: rd_count=%0d m_valid=%b, expected %0d 1",
                     rd_count, m_valid, base + BUF_DEPTH);
        end
        m_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge r_clk);
            checks++;
            if (r_en !== 1'b1 || m_valid !== 1'b1) begin
                errors++;
                $display("FAIL b2b_cycle[%0d]: r_en=%b m_valid=%b, expected 1 1", k, r_en, m_valid);
            end
        end
        wait_drained(100, 1'b0, ok);
        checks++;
        if (!ok || max_out > BUF_DEPTH || rd_count !== 16'(base + 24)) begin
            errors++;
            $display("FAIL b2b_totals: drained=%b max_out=%0d rd_count=%0d, expected 1 <=%0d %0d",
                     ok, max_out, rd_count, BUF_DEPTH, base + 24);
        end
    endtask

    task automatic test_reset_mid_burst();
        bit seen;
        ae_thr = 1;
        m_ready = 1'b0;
        for (int i = 0; i < 10; i++) fifo_q.push_back(F_WIDTH'($urandom));
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge r_clk);
            seen = r_en;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL midrst_no_pop: r_en=%b, expected 1 within 20 cycles", r_en);
        end
        @(negedge r_clk);
        reset = 1'b0;
        #1;
        checks++;
        if ({r_en, m_valid, busy, rd_count} !== '0) begin
            errors++;
            $display("FAIL midrst_immediate: r_en=%b m_valid=%b busy=%b rd_count=%0d, expected all 0",
                     r_en, m_valid, busy, rd_count);
        end
        fifo_q.delete();
        repeat (2) @(negedge r_clk);
        reset = 1'b1;
        for (int i = 0; i < RD_LAT + 4; i++) begin
            @(negedge r_clk);
            checks++;
            if (m_valid !== 1'b0 || rd_count !== 16'd0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL midrst_dropped: m_valid=%b rd_count=%0d busy=%b, expected 0 0 0",
                         m_valid, rd_count, busy);
            end
        end
    endtask

    task automatic test_random();
        bit ok;
        int base;
        int total;
        int n;
        base = int'(rd_count);
        total = 0;
        max_out = 0;
        for (int it = 0; it < 20; it++) begin
            ae_thr = $urandom_range(1, 3);
            n = $urandom_range(1, 12);
            for (int i = 0; i < n; i++) fifo_q.push_back(F_WIDTH'($urandom));
            total += n;
            wait_drained(400, 1'b1, ok);
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL random_drain[%0d]: fifo=%0d pending=%0d busy=%b, expected drained",
                         it, fifo_q.size(), exp_q.size(), busy);
            end
        end
        checks++;
        if (rd_count !== 16'(base + total)) begin
            errors++;
            $display("FAIL random_rd_count: got %0d, expected %0d", rd_count, base + total);
        end
        checks++;
        if (underflows != 0 || empty_viol != 0 || max_out > BUF_DEPTH) begin
            errors++;
            $display("FAIL random_safety: underflows=%0d empty_viol=%0d max_out=%0d, expected 0 0 <=%0d",
                     underflows, empty_viol, max_out, BUF_DEPTH);
        end
    endtask

    task automatic test_counter_wrap();
        bit ok;
        m_ready = 1'b1;
        reset = 1'b0;
        repeat (2) @(negedge r_clk);
        reset = 1'b1;
        ae_thr = 1;
        for (int i = 0; i < 65535; i++) fifo_q.push_back(F_WIDTH'(i));
        wait_drained(70000, 1'b0, ok);
        checks++;
        if (!ok || rd_count !== 16'hFFFF) begin
            errors++;
            $display("FAIL wrap_full: drained=%b rd_count=%0h, expected 1 ffff", ok, rd_count);
        end
        fifo_q.push_back(F_WIDTH'(8'h5A));
        wait_drained(50, 1'b0, ok);
        checks++;
        if (!ok || rd_count !== 16'h0000) begin
            errors++;
            $display("FAIL wrap_zero: drained=%b rd_count=%0h, expected 1 0000", ok, rd_count);
        end
    endtask

    initial begin
        test_reset();
        test_burst_stall();
        test_throttle();
        test_back_to_back();
        test_reset_mid_burst();
        test_random();
        test_counter_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fifo_drain_ctrl.md
# fifo_drain_ctrl

Read-side controller for the `afifo` asynchronous FIFO, living entirely in the read-clock domain. It watches the FIFO's empty and almost-empty flags and drives `r_en` to pop words. Each word taken from `d_out` goes into a small prefetch buffer, and the buffer is presented downstream as a valid/ready stream. Near-empty reads are throttled to one outstanding pop, because the synchronized flags lag the true pointer state.

## Interface
- `F_WIDTH`, 8, data width; must match the FIFO `f_width`.
- `BUF_DEPTH`, 4, prefetch buffer entries; power of two, ≥ 2.
- `RD_LAT`, 1, cycles from `r_en` sampled high to valid `d_out`; legal values 1 or 2.
- `r_clk`  in  1  read-domain clock; all logic on rising edge.
- `reset`  in  1  asynchronous, active-low reset (asserted at 0); deassertion is synchronous to `r_clk` upstream.
- `f_empty_flag`  in  1  FIFO empty.
- `f_almost_empty_flag`  in  1  FIFO almost empty.
- `d_out`  in  F_WIDTH  FIFO read data.
- `r_en`  out  1  FIFO pop request, registered.
- `m_data`  out  F_WIDTH  head-of-buffer word.
- `m_valid`  out  1  `m_data` valid.
- `m_ready`  in  1  downstream accepts when `m_valid & m_ready`.
- `rd_count`  out  16  total words popped, wraps at 0xFFFF→0.
- `busy`  out  1  state ≠ IDLE or in-flight ≠ 0 or occupancy ≠ 0.

## Operation
- **Reset values:** `r_en`=0, `m_valid`=0, `m_data`=0, `rd_count`=0, `busy`=0, state IDLE, occupancy 0, in-flight 0, RD_LAT valid pipe cleared.
- **Credit rule:** a pop may issue only if occupancy + in-flight + (words accepted this cycle ? −1 : 0) < BUF_DEPTH. This guarantees the buffer never overflows.
- **FSM states** (evaluated every cycle; next state depends on the flags sampled this cycle):
  - IDLE: `f_empty_flag`=1; no pops. Goes to BURST if !empty & !almost_empty, or to SINGLE if !empty & almost_empty.
  - BURST: pops every cycle the credit rule allows. Goes to SINGLE when almost_empty=1, or to IDLE when empty=1.
  - SINGLE: issues one pop only when in-flight = 0, so at most one outstanding pop. Goes to BURST when almost_empty=0, or to IDLE when empty=1.
- **Empty has priority** over almost_empty. `r_en` is never asserted in a cycle following a sampled `f_empty_flag`=1.
- **Data capture:** the RD_LAT-deep valid shift register tracks each issued `r_en`. When its tail is 1, `d_out` is written to the buffer tail and in-flight decrements.
- **Buffer:** circular, with `log2(BUF_DEPTH)`-bit pointers that wrap naturally. Occupancy is `log2(BUF_DEPTH)+1` bits. A push and a pop in the same cycle leave occupancy unchanged.
- **Output:** `m_valid` = occupancy ≠ 0. `m_data` shows the head entry, and holds when `m_valid & !m_ready`.
- **Pop counting:** `rd_count` increments on each cycle with `r_en`=1.
- **Reset mid-operation:** everything clears immediately. Data returning after reset deassertion is dropped, because the valid pipe was cleared.

## Timing
- **Latency:** `r_en` high in cycle N → `d_out` captured at end of cycle N+RD_LAT → `m_valid` high in cycle N+RD_LAT+1 when the buffer was empty.
- **Burst throughput:** one word per cycle while in BURST and downstream ready.
- **SINGLE throughput:** one word per RD_LAT+1 cycles.
- **Flags:** `r_en`, `m_valid` and `busy` are registered or derived from registers. There is no combinational path from `m_ready` to `r_en`; `m_ready` affects `r_en` one cycle later through occupancy.

## Structure
- **Shared package `afifo_pkg`:** the state encoding (IDLE=2'b00, BURST=2'b01, SINGLE=2'b10) and the default width/depth constants shared with `afifo`.
- **Sub-module `drain_buf`:** the parameterized circular prefetch buffer (push/pop, occupancy, head data). The FSM, credit logic and latency pipe stay in the top module.

## Test plan
- **Reset:** hold `reset`=0 with flags toggling → all outputs 0. Release → state IDLE, `r_en`=0 while `f_empty_flag`=1.
- **Burst fill, stalled:** FIFO model holds 10 words 1,3,5,…; almost_empty deasserted; `m_ready`=0 → exactly 4 pops, `rd_count`=4, then `m_ready`=1 → `m_data` sequence 1,3,5,7,9,… in order with no gaps or duplicates.
- **Almost-empty throttle:** almost_empty=1 with 3 words → pops spaced RD_LAT+1 cycles apart, never 2 in flight. empty=1 after the third → no 4th `r_en`.
- **Simultaneous push/pop:** buffer full, `m_ready`=1 continuously in BURST → `r_en` high every cycle, occupancy stays at BUF_DEPTH−1/BUF_DEPTH, throughput 1 word/cycle.
- **Reset mid-burst:** assert `reset` with 2 words in flight → `m_valid`=0 at once. After release, the returning words are not captured and `rd_count`=0.
- **Counter wrap:** preload a 65535-pop run → `rd_count` reads 0xFFFF, then 0x0000 after the next pop.
